// File: rtl/display_scan.sv
// display_scan: time-multiplexed BCD digit scanner feeding a seven-segment decoder
// Ports: clk, reset (sync, active-high); value/load capture a new digit set,
// blank_lz enables leading-zero blanking; data is the selected nibble (4'hF = blank),
// digit_en is the one-hot digit select, pending flags a value waiting for the
// frame boundary, frame pulses on the first cycle of each frame.
module display_scan #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] value,
    input  logic                load,
    input  logic                blank_lz,
    output logic [3:0]          data,
    output logic [DIGITS-1:0]   digit_en,
    output logic                pending,
    output logic                frame
);
    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);

    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] staged;
    logic [4*DIGITS-1:0] shadow;
    logic [DIGITS-1:0]   lz;
    logic                tick;
    logic                wrap;
    logic                z;

    assign tick = presc == PW'(PRESCALE - 1);
    assign wrap = tick && idx == IW'(DIGITS - 1);

    // shadow only changes on wrap edges so a frame never mixes two values
    always_ff @(posedge clk) begin
        if (reset) begin
            presc   <= '0;
            idx     <= '0;
            staged  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            frame   <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                idx <= wrap ? '0 : idx + 1'b1;
            frame <= wrap;
            if (wrap) begin
                if (load)
                    shadow <= value;
                else if (pending)
                    shadow <= staged;
                pending <= 1'b0;
            end else if (load) begin
                staged  <= value;
                pending <= 1'b1;
            end
        end
    end

    // lz[k] is set when nibbles k..DIGITS-1 of shadow are all zero
    always_comb begin
        z  = 1'b1;
        lz = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            z     = z && (shadow[4*k +: 4] == 4'd0);
            lz[k] = z;
        end
    end

    assign digit_en = DIGITS'(1) << idx;
    assign data     = (blank_lz && idx != '0 && lz[idx]) ? 4'hF : shadow[4*idx +: 4];
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: scoreboard bench for display_scan with DIGITS=4, PRESCALE=4
module tb_display_scan;
    typedef struct {
        string      tag;
        int         at;
        logic [3:0] data;
        logic [3:0] en;
        logic       pend;
        logic       frm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  data;
    logic [3:0]  digit_en;
    logic        pending;
    logic        frame;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    display_scan #(.DIGITS(4), .PRESCALE(4)) dut (
        .clk(clk),
        .reset(reset),
        .value(value),
        .load(load),
        .blank_lz(blank_lz),
        .data(data),
        .digit_en(digit_en),
        .pending(pending),
        .frame(frame)
    );

    always #5 clk = ~clk;

    // cycles since the last reset edge; frame k starts at cyc 16k
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    // expected outputs for a shown value at a given cycle, derived from the scan schedule
    task automatic push(input string tag, input int at, input logic [15:0] shown, input bit blz, input bit pend);
        exp_t e;
        int   d;
        logic [15:0] upper;
        d     = (at / 4) % 4;
        upper = shown >> (4 * d);
        e.tag  = tag;
        e.at   = at;
        e.data = (blz && d != 0 && upper == 16'd0) ? 4'hF : upper[3:0];
        e.en   = 4'(1 << d);
        e.pend = pend;
        e.frm  = at > 0 && at % 16 == 0;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            assert (e.at == cyc && data === e.data && digit_en === e.en && pending === e.pend && frame === e.frm)
            else begin
                failures++;
                $error("FAIL %s cyc=%0d(at %0d): data=%h en=%b pend=%b frame=%b expected data=%h en=%b pend=%b frame=%b",
                       e.tag, cyc, e.at, data, digit_en, pending, frame, e.data, e.en, e.pend, e.frm);
            end
        end
    end

    task automatic wait_cyc(input int n);
        for (int i = 0; i < 2000 && cyc != n; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        assert (cyc == n) else begin
            failures++;
            $error("FAIL wait_cyc: cyc=%0d expected %0d", cyc, n);
        end
    endtask

    // load is presented while the DUT is in state cyc == sc and sampled on the next edge
    task automatic load_at(input int sc, input logic [15:0] v);
        wait_cyc(sc);
        value = v;
        load  = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c <= 32; c++) push("scan", c, 16'h0000, 0, 0);
        push("defer_pend_rise", 38, 16'h0000, 0, 1);
        push("defer_pend_hold", 47, 16'h0000, 0, 1);
        for (int d = 0; d < 4; d++) push("defer_show", 48 + 4 * d, 16'h1234, 0, 0);
        push("pre_wrap_load", 63, 16'h1234, 0, 0);
        push("wrap_load", 64, 16'h5678, 0, 0);
        push("b2b_pend", 67, 16'h5678, 0, 1);
        push("b2b_hold", 79, 16'h5678, 0, 1);
        push("b2b_last_wins0", 80, 16'h2222, 0, 0);
        push("b2b_last_wins3", 92, 16'h2222, 0, 0);
        for (int d = 0; d < 4; d++) push("lz_0042", 112 + 4 * d, 16'h0042, 1, 0);
        for (int d = 0; d < 4; d++) push("lz_0000", 144 + 4 * d, 16'h0000, 1, 0);
        for (int d = 0; d < 4; d++) push("lz_0402", 176 + 4 * d, 16'h0402, 1, 0);
        push("lz_live_on", 189, 16'h0402, 1, 0);
        push("lz_live_off", 190, 16'h0402, 0, 0);
        for (int d = 0; d < 4; d++) push("lz_off", 192 + 4 * d, 16'h0402, 0, 0);
        push("rst_pend", 211, 16'h0402, 0, 1);

        load_at(37, 16'h1234);
        load_at(63, 16'h5678);
        load_at(66, 16'h1111);
        load_at(67, 16'h2222);
        wait_cyc(100);
        blank_lz = 1'b1;
        load_at(100, 16'h0042);
        load_at(130, 16'h0000);
        load_at(160, 16'h0402);
        wait_cyc(190);
        blank_lz = 1'b0;
        load_at(210, 16'h9999);
        wait_cyc(212);

        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        push("rst_state", 0, 16'h0000, 0, 0);
        push("rst_no_stage", 16, 16'h0000, 0, 0);
        push("rst_no_stage", 20, 16'h0000, 0, 0);
        push("rst_no_stage", 28, 16'h0000, 0, 0);
        wait_cyc(30);
        @(negedge clk);
        #1;
        checks++;
        assert (q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain: left=%0d expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed digit scanner sitting directly upstream of the seven-segment decoder. It holds a multi-digit BCD value in a tear-free shadow register, selects one digit at a time on a fixed refresh cadence, and drives that digit's nibble to the decoder's 4-bit `data` input together with a one-hot digit enable. Optional leading-zero blanking drives 4'hF, which the decoder renders as all segments off.

## Interface
- `DIGITS`, default 4: number of scanned digits, minimum 2.
- `PRESCALE`, default 50000: clock cycles each digit is held, minimum 2.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `value` input, 4*DIGITS bits: BCD digits; nibble k (bits 4k+3:4k) is digit k, and digit 0 is the least significant.
- `load` input, 1 bit: single-cycle strobe that captures `value`.
- `blank_lz` input, 1 bit: enables leading-zero blanking. Sampled live.
- `data` output, 4 bits: nibble fed to the seven-segment decoder.
- `digit_en` output, DIGITS bits: one-hot, active-high enable for the selected digit.
- `pending` output, 1 bit: a loaded value is waiting for the frame boundary.
- `frame` output, 1 bit: one-cycle pulse at the start of each scan frame.

## Operation
- Registers:
  - `presc`: counts 0..PRESCALE-1.
  - `idx`: counts 0..DIGITS-1.
  - `staged`: 4*DIGITS bits.
  - `shadow`: 4*DIGITS bits.
  - `pending`.
  - `frame`.
- Tick: asserted when presc == PRESCALE-1. On a tick, presc goes to 0 and idx increments. Otherwise presc increments.
- Wrap: a tick while idx == DIGITS-1. idx goes to 0 and frame is set to 1 for the next cycle only.
- Load handling, with priority from top to bottom:
  - Wrap edge with load=1: shadow <= value and pending <= 0. `staged` is don't-care.
  - Wrap edge with load=0 and pending=1: shadow <= staged and pending <= 0.
  - Non-wrap edge with load=1: staged <= value and pending <= 1. Back-to-back loads are last-wins.
- shadow changes only on wrap edges, so a frame never shows a mix of two values.
- `digit_en` = 1 << idx.
- `data`:
  - Normally data = shadow nibble idx.
  - Leading-zero blanking: data = 4'hF when blank_lz=1, idx != 0, and nibbles idx..DIGITS-1 of shadow are all zero.
  - Digit 0 is never blanked.
- Non-BCD nibbles (A–E) pass through unchanged; the decoder blanks them.
- `data` and `digit_en` are functions of registered state plus blank_lz only. There is no combinational path from `value` or `load`.

## Timing
- Reset values, on the edge where reset=1:
  - presc=0, idx=0, shadow=0, staged=0.
  - pending=0, frame=0.
  - Resulting outputs: digit_en=…0001 and data=0.
- Reset overrides everything, including a simultaneous load or wrap. A load lost to reset is discarded.
- Each digit is held exactly PRESCALE cycles. A frame is DIGITS*PRESCALE cycles.
- idx, digit_en and data change on the same edge.
- frame is high for the first cycle of every frame after the first. There is no pulse immediately after reset.
- Load latency to display:
  - Load on the wrap cycle: visible the next cycle.
  - Any other load: visible from the next wrap edge, worst case DIGITS*PRESCALE-1 cycles later.
- pending rises on the edge after a non-wrap load and falls on the wrap edge that updates shadow.

## Test plan
- Reset and scan with DIGITS=4, PRESCALE=4: release reset → digit_en runs 0001, 0010, 0100, 1000, holding 4 cycles each; frame pulses every 16 cycles, first pulse 16 cycles after reset release; data=0 throughout.
- Deferred load: value=16'h1234 with load at frame cycle 5 → pending=1 from cycle 6; shadow unchanged until wrap; then data reads 4, 3, 2, 1 for digits 0..3 and pending=0.
- Load on the wrap cycle plus back-to-back loads:
  - load 16'h5678 exactly on the wrap tick → digit 0 shows 8 on the next cycle with no pending.
  - loads of 16'h1111 then 16'h2222 mid-frame → 16'h2222 is displayed.
- Leading-zero blanking:
  - 16'h0042 with blank_lz=1 → digits 3 and 2 give data=F; digits 1 and 0 give 4 and 2.
  - 16'h0000 → F, F, F on digits 3..1 and 0 on digit 0.
  - 16'h0402 → digit 2 shows 4 and digit 1 shows 0 (not blanked).
  - blank_lz=0 → all nibbles shown.
- Reset mid-frame with pending=1 → next cycle idx=0, pending=0, shadow=0; the staged value is never displayed.
